hilo_mult_sequencer: RTL
========================

HILO_MULT_SEQUENCER -- requirements
Module: hilo_mult_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` is the single clock and `rst` is the reset.
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  mult/multu issued in EX (enhilo_EX)
- is_signed  in  1  1=mult, 0=multu
- src_a  in  32  rs operand
- src_b  in  32  rt operand
- regsel  in  2  01=mfhi, 10=mflo, 00=other, 11=reserved (treated as other)
- busy  out  1  multiply in progress
- stall  out  1  freeze fetch/decode/EX
- done  out  1  one-cycle pulse, HI/LO just updated
- hi  out  32  HI register
- lo  out  32  LO register

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, MULT, FIX.
REQ-004 In IDLE with start=1, the block SHALL, at the clock edge:
- capture |src_a| and |src_b| (two's-complement magnitude if is_signed, raw value otherwise);
- capture neg = is_signed & (src_a[31] ^ src_b[31]);
- clear the 64-bit accumulator and the 6-bit counter;
- enter MULT.
REQ-005 In MULT, each cycle SHALL perform one shift-add step:
- if multiplier bit0=1, add the multiplicand into accumulator[63:32] with a 33-bit carry;
- shift {carry, accumulator} and the multiplier right by 1;
- increment the counter.
REQ-006 MULT SHALL last exactly 32 cycles, then enter FIX.
REQ-007 In FIX, the block SHALL write hi/lo = neg ? -accumulator : accumulator (64-bit two's complement), assert done for that one cycle, and return to IDLE.
REQ-008 Latency SHALL be 33 cycles: if start is sampled at edge N, hi/lo take the new values at edge N+33, and done is high during the cycle following edge N+33.
REQ-009 busy SHALL be 1 whenever state≠IDLE.
REQ-010 stall SHALL be combinational: busy & (regsel==01 | regsel==10 | start).
REQ-011 start while busy SHALL be ignored; upstream holds the instruction under stall and re-presents it after the current operation completes.
REQ-012 start in IDLE on the same cycle as regsel≠00 SHALL NOT be possible (one EX instruction at a time); behaviour in that case is unspecified.
REQ-013 hi and lo SHALL hold their values at all times except at the FIX edge and reset.
REQ-014 Magnitude of 0x80000000 SHALL be 0x80000000, handled as 32-bit unsigned with no overflow.

Reset
REQ-015 When rst=1 at a clock edge, the block SHALL set state=IDLE, hi=0, lo=0, busy=0, done=0, and clear the accumulator and counter.
REQ-016 Reset mid-MULT or mid-FIX SHALL abort the operation and leave no partial write to HI/LO.
REQ-017 Reset SHALL take priority over start.

Structure
REQ-018 The shared package SHALL hold:
- the state enum (IDLE/MULT/FIX);
- MULT_CYCLES=32;
- REGSEL_NONE/REGSEL_HI/REGSEL_LO encodings, shared with controlUnit.
REQ-019 One sub-module, mult_shift_add_dp, SHALL hold the magnitude/accumulator/shift datapath, with the FSM and HI/LO registers kept in the top level.

Verification
REQ-020 multu, src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001.
REQ-021 mult, src_a=0xFFFFFFFB (-5), src_b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; a second case with src_a=-5, src_b=0 -> hi=0, lo=0.
REQ-022 mult, src_a=src_b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-023 regsel=01 held from cycle 2 after start -> stall=1 through the FIX cycle, 0 the cycle after; start re-asserted during MULT -> stall=1, no restart, hi/lo from the first operation only.
REQ-024 rst asserted at MULT cycle 10 after prior hi=0x12345678 -> next cycle state IDLE, hi=lo=0, done never pulses, busy=0.
REQ-025 Back-to-back: start re-asserted in the cycle after done -> second result 33 cycles later; hi/lo stable between the two done pulses.

Source files
------------

// File: rtl/hilo_mult_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply sequencer and the control unit.
package hilo_mult_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    FIX  = 2'd2
  } mult_state_t;

  localparam int MULT_CYCLES = 32;

  localparam logic [1:0] REGSEL_NONE = 2'b00;
  localparam logic [1:0] REGSEL_HI   = 2'b01;
  localparam logic [1:0] REGSEL_LO   = 2'b10;

  // Unsigned magnitude of an operand; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/hilo_mult_sequencer_dp.sv
// Shift-add datapath: operand magnitudes, 64-bit accumulator and step counter.
module mult_shift_add_dp
  import hilo_mult_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_signed,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] acc,
  output logic        neg,
  output logic [5:0]  count
);

  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [32:0] sum;

  // Upper accumulator half plus the multiplicand when the current multiplier bit is set.
  always_comb begin
    sum = {1'b0, acc[63:32]} + (mplier[0] ? {1'b0, mcand} : 33'd0);
  end

  // Load magnitudes on start, then shift {carry, accumulator} and multiplier once per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= 64'd0;
      count  <= 6'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= magnitude(src_a, is_signed);
      mplier <= magnitude(src_b, is_signed);
      neg    <= is_signed & (src_a[31] ^ src_b[31]);
      acc    <= 64'd0;
      count  <= 6'd0;
    end else if (step) begin
      acc    <= {sum, acc[31:1]};
      mplier <= {1'b0, mplier[31:1]};
      count  <= count + 6'd1;
    end
  end

endmodule

// File: rtl/hilo_mult_sequencer.sv
// Sequencer for mult/multu: 32-cycle shift-add multiply, sign fix-up, HI/LO registers.
module hilo_mult_sequencer
  import hilo_mult_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  regsel,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mult_state_t state;
  logic [63:0] acc;
  logic        neg;
  logic [5:0]  count;
  logic        load;
  logic        step;

  assign load = (state == IDLE) && start;
  assign step = (state == MULT);

  mult_shift_add_dp u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .is_signed (is_signed),
    .src_a     (src_a),
    .src_b     (src_b),
    .acc       (acc),
    .neg       (neg),
    .count     (count)
  );

  // Busy and stall decode; a HI/LO read or a new multiply must wait while one is running.
  always_comb begin
    busy  = (state != IDLE);
    stall = busy && ((regsel == REGSEL_HI) || (regsel == REGSEL_LO) || start);
  end

  // Control FSM; HI/LO only change on the FIX edge, so an aborted multiply never writes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi    <= 32'd0;
      lo    <= 32'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) state <= MULT;
        end
        MULT: begin
          if (count == 6'(MULT_CYCLES - 1)) state <= FIX;
        end
        FIX: begin
          {hi, lo} <= neg ? (~acc + 64'd1) : acc;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
